// File: rtl/pong_match_ctrl.sv
// N-player pong match controller: idle/serve/play/refill/over sequencing, shared ball pool and per-player scores.
// Optional PONG_PAUSE_EN adds a pause input and a HOLD state that suspends PLAY.
module pong_match_ctrl #(
   parameter int NUM_PLAYERS  = 2,
   parameter int BALLS        = 3,
   parameter int WIN_SCORE    = 7,
   parameter int SCORE_W      = 4,
   parameter int PAUSE_FRAMES = 60,
   parameter int TMR_W        = 7
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             frame_tick,
   input  logic                             serve,
`ifdef PONG_PAUSE_EN
   input  logic                             pause,
`endif
   input  logic [NUM_PLAYERS-1:0]           hit,
   input  logic [NUM_PLAYERS-1:0]           missed,
   output logic                             ball_restart,
   output logic                             score_clr,
   output logic                             playing,
   output logic                             game_over,
   output logic [$clog2(BALLS+1)-1:0]       balls_left,
   output logic [NUM_PLAYERS*SCORE_W-1:0]   scores,
   output logic [NUM_PLAYERS-1:0]           winner
);

   localparam int BAL_W = $clog2(BALLS+1);
   localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SERVE,
      S_PLAY,
      S_REFILL,
      S_OVER
`ifdef PONG_PAUSE_EN
      , S_HOLD
`endif
   } state_t;

   state_t               state_q, state_d;
   logic [BAL_W-1:0]     balls_q, balls_d;
   logic [SCORE_W-1:0]   score_q [NUM_PLAYERS];
   logic [SCORE_W-1:0]   score_d [NUM_PLAYERS];
   logic                 last_vld_q, last_vld_d;
   logic [IDX_W-1:0]     last_idx_q, last_idx_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic [NUM_PLAYERS-1:0] winner_q, winner_d;
   logic                 ball_restart_q, ball_restart_d;
   logic                 score_clr_q, score_clr_d;
   logic                 playing_q, playing_d;
   logic                 game_over_q, game_over_d;

   logic                 hit_any, miss_any, win_hit;
   logic [IDX_W-1:0]     hit_idx, miss_idx;
   logic [SCORE_W-1:0]   new_score, max_s;
   logic [NUM_PLAYERS-1:0] uniq;
   int unsigned          max_cnt;

   always_comb begin
      state_d     = state_q;
      balls_d     = balls_q;
      score_d     = score_q;
      last_vld_d  = last_vld_q;
      last_idx_d  = last_idx_q;
      timer_d     = timer_q;
      winner_d    = winner_q;
      score_clr_d = 1'b0;
      win_hit     = 1'b0;
      new_score   = '0;

      // Scan high to low so the lowest set index wins.
      hit_any  = |hit;
      miss_any = |missed;
      hit_idx  = '0;
      miss_idx = '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
         if (hit[NUM_PLAYERS-1-i])    hit_idx  = IDX_W'(NUM_PLAYERS-1-i);
         if (missed[NUM_PLAYERS-1-i]) miss_idx = IDX_W'(NUM_PLAYERS-1-i);
      end

      case (state_q)
         S_IDLE: begin
            if (serve) begin
               for (int unsigned i = 0; i < NUM_PLAYERS; i++) score_d[i] = '0;
               balls_d     = BAL_W'(BALLS);
               winner_d    = '0;
               score_clr_d = 1'b1;
               state_d     = S_SERVE;
            end
         end
         S_SERVE: begin
            if (serve) begin
               last_vld_d = 1'b0;
               state_d    = S_PLAY;
            end
         end
         S_PLAY: begin
`ifdef PONG_PAUSE_EN
            if (pause) begin
               state_d = S_HOLD;
            end else
`endif
            begin
               if (hit_any) begin
                  last_vld_d = 1'b1;
                  last_idx_d = hit_idx;
               end
               if (miss_any) begin
                  if (last_vld_d && (last_idx_d != miss_idx)) begin
                     new_score = score_q[last_idx_d];
                     if (new_score != '1) new_score = new_score + 1'b1;
                     score_d[last_idx_d] = new_score;
                     win_hit = (new_score == SCORE_W'(WIN_SCORE));
                  end
                  balls_d = balls_q - 1'b1;
                  timer_d = TMR_W'(PAUSE_FRAMES);
                  state_d = (win_hit || (balls_q == BAL_W'(1))) ? S_OVER : S_REFILL;
               end
            end
         end
         S_REFILL: begin
            if (frame_tick && (timer_q != '0)) timer_d = timer_q - 1'b1;
            if (timer_q == '0) state_d = S_SERVE;
         end
         S_OVER: begin
            if (frame_tick && (timer_q != '0)) timer_d = timer_q - 1'b1;
            if (timer_q == '0) state_d = S_IDLE;
         end
`ifdef PONG_PAUSE_EN
         S_HOLD: begin
            if (!pause) state_d = S_PLAY;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Winner is judged on the post-update scores and frozen on OVER entry.
      max_s = '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++)
         if (score_d[i] > max_s) max_s = score_d[i];
      max_cnt = 0;
      uniq    = '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
         if (score_d[i] == max_s) begin
            max_cnt = max_cnt + 1;
            uniq[i] = 1'b1;
         end
      end
      if (max_cnt != 1) uniq = '0;
      if ((state_d == S_OVER) && (state_q != S_OVER)) winner_d = uniq;

`ifdef PONG_PAUSE_EN
      ball_restart_d = !((state_d == S_PLAY) || (state_d == S_HOLD));
`else
      ball_restart_d = (state_d != S_PLAY);
`endif
      playing_d   = (state_d == S_PLAY);
      game_over_d = (state_d == S_OVER);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         balls_q        <= BAL_W'(BALLS);
         for (int unsigned i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
         last_vld_q     <= 1'b0;
         last_idx_q     <= '0;
         timer_q        <= '0;
         winner_q       <= '0;
         ball_restart_q <= 1'b1;
         score_clr_q    <= 1'b0;
         playing_q      <= 1'b0;
         game_over_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         balls_q        <= balls_d;
         score_q        <= score_d;
         last_vld_q     <= last_vld_d;
         last_idx_q     <= last_idx_d;
         timer_q        <= timer_d;
         winner_q       <= winner_d;
         ball_restart_q <= ball_restart_d;
         score_clr_q    <= score_clr_d;
         playing_q      <= playing_d;
         game_over_q    <= game_over_d;
      end
   end

   always_comb begin
      scores = '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++)
         scores[i*SCORE_W +: SCORE_W] = score_q[i];
   end

   assign ball_restart = ball_restart_q;
   assign score_clr    = score_clr_q;
   assign playing      = playing_q;
   assign game_over    = game_over_q;
   assign balls_left   = balls_q;
   assign winner       = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: 2 players, 8 balls so both the win-score and ball-exhaustion endings are reachable.
module tb_pong_match_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic       serve;
   logic [1:0] hit;
   logic [1:0] missed;
   logic       ball_restart, score_clr, playing, game_over;
   logic [3:0] balls_left;
   logic [7:0] scores;
   logic [1:0] winner;

   int checks   = 0;
   int failures = 0;

   pong_match_ctrl #(
      .NUM_PLAYERS (2),
      .BALLS       (8),
      .WIN_SCORE   (7),
      .SCORE_W     (4),
      .PAUSE_FRAMES(60),
      .TMR_W       (7)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .serve       (serve),
      .hit         (hit),
      .missed      (missed),
      .ball_restart(ball_restart),
      .score_clr   (score_clr),
      .playing     (playing),
      .game_over   (game_over),
      .balls_left  (balls_left),
      .scores      (scores),
      .winner      (winner)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic [1:0] h, input logic [1:0] m);
      hit    = h;
      missed = m;
      tick();
      hit    = 2'b00;
      missed = 2'b00;
   endtask

   // Expects REFILL with timer=60 and serve held high; returns in PLAY.
   task automatic refill();
      for (int i = 0; i < 59; i++) begin
         frame_tick = 1'b1; tick();
         frame_tick = 1'b0; tick();
      end
      chk("refill_59", {31'd0, playing}, 32'd0);
      frame_tick = 1'b1; tick();
      chk("refill_60", {31'd0, playing}, 32'd0);
      frame_tick = 1'b0; tick();
      chk("refill_serve", {31'd0, playing}, 32'd0);
      tick();
      chk("refill_play", {31'd0, playing}, 32'd1);
   endtask

   // Expects OVER with timer=60 and serve low; returns in IDLE.
   task automatic over_wait();
      for (int i = 0; i < 59; i++) begin
         frame_tick = 1'b1; tick();
         frame_tick = 1'b0; tick();
      end
      chk("over_59", {31'd0, game_over}, 32'd1);
      frame_tick = 1'b1; tick();
      chk("over_60", {31'd0, game_over}, 32'd1);
      frame_tick = 1'b0; tick();
      chk("over_idle", {31'd0, game_over}, 32'd0);
      chk("over_idle_restart", {31'd0, ball_restart}, 32'd1);
   endtask

   initial begin
      reset = 1'b1; frame_tick = 1'b0; serve = 1'b0; hit = '0; missed = '0;
      tick(); tick();
      chk("rst_restart", {31'd0, ball_restart}, 32'd1);
      chk("rst_clr", {31'd0, score_clr}, 32'd0);
      chk("rst_playing", {31'd0, playing}, 32'd0);
      chk("rst_over", {31'd0, game_over}, 32'd0);
      chk("rst_balls", {28'd0, balls_left}, 32'd8);
      chk("rst_scores", {24'd0, scores}, 32'd0);
      chk("rst_winner", {30'd0, winner}, 32'd0);
      reset = 1'b0;
      tick();
      chk("idle_hold", {31'd0, ball_restart}, 32'd1);

      // Match 1: ends on ball exhaustion with a draw.
      serve = 1'b1;
      tick();
      chk("m1_clr", {31'd0, score_clr}, 32'd1);
      chk("m1_serve_restart", {31'd0, ball_restart}, 32'd1);
      chk("m1_serve_playing", {31'd0, playing}, 32'd0);
      tick();
      chk("m1_clr_end", {31'd0, score_clr}, 32'd0);
      chk("m1_playing", {31'd0, playing}, 32'd1);
      chk("m1_play_restart", {31'd0, ball_restart}, 32'd0);
      chk("m1_balls", {28'd0, balls_left}, 32'd8);

      pulse(2'b01, 2'b00);
      pulse(2'b00, 2'b10);
      chk("pt1_scores", {24'd0, scores}, 32'h01);
      chk("pt1_balls", {28'd0, balls_left}, 32'd7);
      chk("pt1_restart", {31'd0, ball_restart}, 32'd1);
      refill();

      pulse(2'b00, 2'b01);
      chk("pt2_nohit_scores", {24'd0, scores}, 32'h01);
      chk("pt2_balls", {28'd0, balls_left}, 32'd6);
      refill();

      pulse(2'b10, 2'b11);
      chk("pt3_same_cycle", {24'd0, scores}, 32'h11);
      chk("pt3_balls", {28'd0, balls_left}, 32'd5);
      refill();

      pulse(2'b01, 2'b01);
      chk("pt4_own_miss", {24'd0, scores}, 32'h11);
      chk("pt4_balls", {28'd0, balls_left}, 32'd4);
      refill();

      pulse(2'b11, 2'b00);
      pulse(2'b00, 2'b01);
      chk("pt5_lowest_hit", {24'd0, scores}, 32'h11);
      refill();
      pulse(2'b00, 2'b10);
      refill();
      pulse(2'b00, 2'b01);
      chk("pt7_balls", {28'd0, balls_left}, 32'd1);
      chk("pt7_not_over", {31'd0, game_over}, 32'd0);
      refill();

      pulse(2'b00, 2'b10);
      serve = 1'b0;
      chk("draw_balls", {28'd0, balls_left}, 32'd0);
      chk("draw_over", {31'd0, game_over}, 32'd1);
      chk("draw_winner", {30'd0, winner}, 32'd0);
      chk("draw_playing", {31'd0, playing}, 32'd0);
      over_wait();
      chk("idle_scores_kept", {24'd0, scores}, 32'h11);

      // Match 2: player 0 wins 7-0 before the balls run out.
      serve = 1'b1;
      tick();
      chk("m2_clr", {31'd0, score_clr}, 32'd1);
      chk("m2_scores_clr", {24'd0, scores}, 32'd0);
      chk("m2_balls", {28'd0, balls_left}, 32'd8);
      tick();
      chk("m2_playing", {31'd0, playing}, 32'd1);
      for (int k = 1; k <= 7; k++) begin
         pulse(2'b01, 2'b00);
         pulse(2'b00, 2'b10);
         chk("m2_score", {24'd0, scores}, k);
         if (k < 7) begin
            chk("m2_not_over", {31'd0, game_over}, 32'd0);
            refill();
         end
      end
      serve = 1'b0;
      chk("win_over", {31'd0, game_over}, 32'd1);
      chk("win_winner", {30'd0, winner}, 32'd1);
      chk("win_balls", {28'd0, balls_left}, 32'd1);
      chk("win_restart", {31'd0, ball_restart}, 32'd1);
      over_wait();

      // Match 3: asynchronous reset during REFILL.
      serve = 1'b1;
      tick(); tick();
      pulse(2'b01, 2'b00);
      pulse(2'b00, 2'b10);
      serve = 1'b0;
      chk("m3_scores", {24'd0, scores}, 32'h01);
      chk("m3_balls", {28'd0, balls_left}, 32'd7);
      repeat (5) begin
         frame_tick = 1'b1; tick();
         frame_tick = 1'b0; tick();
      end
      #2 reset = 1'b1;
      #1;
      chk("arst_scores", {24'd0, scores}, 32'd0);
      chk("arst_balls", {28'd0, balls_left}, 32'd8);
      chk("arst_restart", {31'd0, ball_restart}, 32'd1);
      reset = 1'b0;
      tick();
      chk("arst_idle_clr", {31'd0, score_clr}, 32'd0);
      chk("arst_idle_playing", {31'd0, playing}, 32'd0);
      serve = 1'b1;
      tick();
      chk("arst_serve_clr", {31'd0, score_clr}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
